pe_seq_ctrl: RTL and testbench
==============================

// Module: pe_seq_ctrl
// PURPOSE
//  Sequencer for one MAC processing element (8b ifm x 8b weight -> 32b psum).
//  Fetches a vector of ifm/weight operand pairs from two sync-read buffers, clears the PE,
//  streams the pairs into it one per cycle and captures the final psum.
//  Presents the psum on a valid/ready result port. Sits between the layer scheduler and a PE.
// PARAMETERS
//  WIDTH     8   operand width (ifm and weight)
//  AW        5   buffer address width; max vector length 2**AW-1
//  PSUM_W    32  psum/result width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high
//  start         in   1       request one dot product; accepted only when busy==0
//  base_addr     in   AW      first buffer address, sampled on accept
//  len           in   AW      number of operand pairs, sampled on accept
//  busy          out  1       high from the cycle after accept until result handshake
//  buf_rd_en     out  1       read strobe to both buffers
//  buf_addr      out  AW      shared read address
//  buf_ifm       in   WIDTH   ifm read data, valid 1 cycle after buf_rd_en
//  buf_w         in   WIDTH   weight read data, valid 1 cycle after buf_rd_en
//  pe_ifm        out  WIDTH   registered operand to PE
//  pe_w          out  WIDTH   registered operand to PE
//  pe_clr        out  1       1-cycle pulse, PE zeroes its accumulator
//  pe_acc_en     out  1       PE accumulates pe_ifm*pe_w at next edge
//  pe_psum       in   PSUM_W  PE accumulator, valid the cycle after the last pe_acc_en
//  result        out  PSUM_W  captured psum, stable while result_valid
//  result_valid  out  1       result available; held until result_ready
//  result_ready  in   1       consumer accepts result
// BEHAVIOUR
//  Reset: state=IDLE; busy, buf_rd_en, pe_clr, pe_acc_en, result_valid = 0;
//   buf_addr, pe_ifm, pe_w, result = 0. Reset mid-operation drops the partial sum, no result.
//  FSM: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//   IDLE : start=1 -> latch base_addr/len, addr counter=base, remaining=len; len==0 -> DONE
//          with result=0 (no buffer reads, no pe_clr); else -> FETCH.
//   FETCH: buf_rd_en=1, buf_addr=counter, counter+1 each cycle for len cycles; pe_clr=1 in
//          first FETCH cycle only. After len-th read -> DRAIN.
//   DRAIN: wait until last operand pair has been accumulated, then result<=pe_psum -> DONE.
//   DONE : result_valid=1; result_ready=1 -> IDLE (result_valid falls next cycle).
//  Operand pipe: rd_vld_d <= buf_rd_en; on rd_vld_d, pe_ifm<=buf_ifm, pe_w<=buf_w, pe_acc_en<=1;
//   otherwise pe_acc_en<=0 and pe_ifm/pe_w hold 0 (never feed stale data to the PE).
//  Timing (edge 0 samples start, len=N>=1): reads at edges 1..N; pe_acc_en high for cycles
//   after edges 3..N+2; result captured at edge N+4; result_valid high from edge N+4.
//  Address wraps modulo 2**AW (base+len may exceed range; wrap is legal, not an error).
//  start while busy or result_valid is ignored, incl. same cycle as result_ready handshake.
//  Unsigned arithmetic; psum never saturates (2**AW-1 products of 8b fit in 32b).
// CONFIGURATION
//  PE_CTRL_PERF_CNT_EN defined: adds output perf_cycles[31:0], counts cycles with busy=1,
//   free-running across operations, wraps at 2**32, cleared only by rst.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  len=4, ifm={1,2,3,4}, w={5,6,7,8}, base=0 -> result=70, result_valid at edge 8, 4 reads.
//  len=0 -> result_valid at edge 1 with result=0, buf_rd_en and pe_clr never asserted.
//  len=2, base=31 (AW=5) -> buf_addr 31 then 0; result = ifm[31]*w[31]+ifm[0]*w[0].
//  result_ready low 10 cycles -> result/result_valid stable; start pulses ignored meanwhile.
//  Back-to-back: second op after first sums 70 -> pe_clr pulses, second result independent.
//  rst asserted during FETCH -> all outputs 0 next cycle, no result_valid; new start works.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pe_seq_ctrl
//  Sequencer for one MAC processing element. For each accepted request it
//  reads a vector of ifm/weight pairs from two sync-read buffers, clears the
//  PE, streams the pairs into it one per cycle, captures the final psum and
//  offers it on a valid/ready result port.
//
//  Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               request; accepted only while idle
//   base_addr, len      first buffer address / pair count, sampled on accept
//   busy                high from the cycle after accept until result handshake
//   buf_rd_en, buf_addr read strobe and shared address for both buffers
//   buf_ifm, buf_w      buffer read data, valid one cycle after buf_rd_en
//   pe_ifm, pe_w        registered operands to the PE (0 when not accumulating)
//   pe_clr              one-cycle accumulator clear pulse
//   pe_acc_en           PE accumulates pe_ifm*pe_w at the next edge
//   pe_psum             PE accumulator value
//   result              captured psum, stable while result_valid
//   result_valid        result available, held until result_ready
//   result_ready        consumer accepts result
//   perf_cycles         (PE_CTRL_PERF_CNT_EN only) count of busy cycles
//
//  Optional feature macro: PE_CTRL_PERF_CNT_EN
// ---------------------------------------------------------------------------
module pe_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int AW     = 5,
  parameter int PSUM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW-1:0]     len,
  output logic              busy,
  output logic              buf_rd_en,
  output logic [AW-1:0]     buf_addr,
  input  logic [WIDTH-1:0]  buf_ifm,
  input  logic [WIDTH-1:0]  buf_w,
  output logic [WIDTH-1:0]  pe_ifm,
  output logic [WIDTH-1:0]  pe_w,
  output logic              pe_clr,
  output logic              pe_acc_en,
  input  logic [PSUM_W-1:0] pe_psum,
`ifdef PE_CTRL_PERF_CNT_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic [PSUM_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr_cnt;
  logic [AW-1:0]   remaining;
  logic            first_rd;
  logic            rd_vld_d;   // buffer data valid this cycle

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      remaining    <= '0;
      first_rd     <= 1'b0;
      rd_vld_d     <= 1'b0;
      busy         <= 1'b0;
      buf_rd_en    <= 1'b0;
      buf_addr     <= '0;
      pe_ifm       <= '0;
      pe_w         <= '0;
      pe_clr       <= 1'b0;
      pe_acc_en    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      // Operand pipe: forward read data only when it is valid, otherwise
      // zeros so the PE never sees stale operands.
      rd_vld_d <= buf_rd_en;
      if (rd_vld_d) begin
        pe_ifm    <= buf_ifm;
        pe_w      <= buf_w;
        pe_acc_en <= 1'b1;
      end else begin
        pe_ifm    <= '0;
        pe_w      <= '0;
        pe_acc_en <= 1'b0;
      end

      pe_clr    <= 1'b0;
      buf_rd_en <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            addr_cnt  <= base_addr;
            remaining <= len;
            first_rd  <= 1'b1;
            if (len == '0) begin
              // Empty vector: no reads, no PE clear, result is zero.
              result <= '0;
              state  <= DONE;
            end else begin
              state  <= FETCH;
            end
          end
        end

        FETCH: begin
          buf_rd_en <= 1'b1;
          buf_addr  <= addr_cnt;
          addr_cnt  <= addr_cnt + 1'b1;   // wraps modulo 2**AW
          remaining <= remaining - 1'b1;
          pe_clr    <= first_rd;
          first_rd  <= 1'b0;
          if (remaining == AW'(1)) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          // Pipeline empty (no read in flight, no operand pending, no
          // accumulate this cycle) means pe_psum holds the final sum.
          if (!buf_rd_en && !rd_vld_d && !pe_acc_en) begin
            result       <= pe_psum;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            result_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_CNT_EN
  // Free-running busy-cycle counter, wraps naturally at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
module tb_pe_seq_ctrl;
  localparam int WIDTH  = 8;
  localparam int AW     = 5;
  localparam int PSUM_W = 32;
  localparam int DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     len;
  logic              busy;
  logic              buf_rd_en;
  logic [AW-1:0]     buf_addr;
  logic [WIDTH-1:0]  buf_ifm;
  logic [WIDTH-1:0]  buf_w;
  logic [WIDTH-1:0]  pe_ifm;
  logic [WIDTH-1:0]  pe_w;
  logic              pe_clr;
  logic              pe_acc_en;
  logic [PSUM_W-1:0] pe_psum;
  logic [PSUM_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
`ifdef PE_CTRL_PERF_CNT_EN
  logic [31:0]       perf_cycles;
`endif

  always #5 clk = ~clk;

  pe_seq_ctrl #(.WIDTH(WIDTH), .AW(AW), .PSUM_W(PSUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .buf_rd_en(buf_rd_en), .buf_addr(buf_addr),
    .buf_ifm(buf_ifm), .buf_w(buf_w), .pe_ifm(pe_ifm), .pe_w(pe_w),
    .pe_clr(pe_clr), .pe_acc_en(pe_acc_en), .pe_psum(pe_psum),
`ifdef PE_CTRL_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  // Environment: two sync-read buffers and a MAC PE.
  logic [WIDTH-1:0] mem_ifm [DEPTH];
  logic [WIDTH-1:0] mem_w   [DEPTH];

  always @(posedge clk) begin
    if (buf_rd_en) begin
      buf_ifm <= mem_ifm[buf_addr];
      buf_w   <= mem_w[buf_addr];
    end
  end

  always @(posedge clk) begin
    if (rst || pe_clr) pe_psum <= '0;
    else if (pe_acc_en) pe_psum <= pe_psum + 32'(pe_ifm) * 32'(pe_w);
  end

  // Bus monitor, sampled mid-cycle.
  int   addr_q[$];
  int   clr_cnt;
  always @(negedge clk) begin
    if (buf_rd_en) addr_q.push_back(int'(buf_addr));
    if (pe_clr) clr_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: dot product over a wrapped address window.
  function automatic logic [31:0] ref_dot(input int base, input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) begin
      int idx = (base + i) % DEPTH;
      s += 32'(mem_ifm[idx]) * 32'(mem_w[idx]);
    end
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_ifm[i] = WIDTH'($urandom);
      mem_w[i]   = WIDTH'($urandom);
    end
  endtask

  // Runs one operation starting at a negedge; ends at a negedge, idle.
  task automatic run_op(input int base, input int n, input int stall, input bit pulse_start);
    logic [31:0] expv;
    int k;
    expv = ref_dot(base, n);
    addr_q.delete();
    clr_cnt = 0;
    start = 1'b1; base_addr = AW'(base); len = AW'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!result_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    $display("op base=%0d len=%0d -> result=%0d expected=%0d edges=%0d", base, n, result, expv, k);
    check("latency", 32'(k), (n == 0) ? 32'd1 : 32'(n + 4));
    check("result", result, expv);
    check("read_count", 32'(addr_q.size()), 32'(n));
    for (int i = 0; i < addr_q.size() && i < n; i++)
      check("read_addr", 32'(addr_q[i]), 32'((base + i) % DEPTH));
    check("clr_count", 32'(clr_cnt), (n == 0) ? 32'd0 : 32'd1);
    for (int c = 0; c < stall; c++) begin
      if (pulse_start) begin
        start = 1'b1; base_addr = AW'($urandom); len = 5'd3;
      end
      @(negedge clk);
      start = 1'b0;
      check("stall_valid", 32'(result_valid), 32'd1);
      check("stall_result", result, expv);
    end
    check("stall_no_reads", 32'(addr_q.size()), 32'(n));
    result_ready = 1'b1;
    if (pulse_start) begin
      start = 1'b1; base_addr = 5'd1; len = 5'd2;
    end
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    check("valid_drop", 32'(result_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; result_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mem_ifm[i] = '0; mem_w[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(buf_rd_en), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_addr", 32'(buf_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector: 1*5+2*6+3*7+4*8 = 70.
    for (int i = 0; i < 4; i++) begin
      mem_ifm[i] = WIDTH'(i + 1);
      mem_w[i]   = WIDTH'(i + 5);
    end
    run_op(0, 4, 0, 1'b0);
    // Back-to-back, independent second result.
    mem_ifm[8] = 8'd10; mem_w[8] = 8'd3;
    mem_ifm[9] = 8'd20; mem_w[9] = 8'd2;
    run_op(8, 2, 0, 1'b0);
    // Empty vector.
    run_op(5, 0, 0, 1'b0);
    // Address wrap.
    mem_ifm[31] = 8'd200; mem_w[31] = 8'd100;
    mem_ifm[0]  = 8'd7;   mem_w[0]  = 8'd9;
    run_op(31, 2, 0, 1'b0);
    // Held result with ignored start pulses.
    run_op(0, 4, 10, 1'b1);

    // Reset during FETCH.
    start = 1'b1; base_addr = 5'd2; len = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("fetch_rd_en", 32'(buf_rd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(buf_rd_en), 32'd0);
    check("midrst_addr", 32'(buf_addr), 32'd0);
    check("midrst_clr", 32'(pe_clr), 32'd0);
    check("midrst_acc", 32'(pe_acc_en), 32'd0);
    check("midrst_ops", 32'({pe_ifm, pe_w}), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(result_valid), 32'd0);
    run_op(0, 4, 0, 1'b0);

    // Randomized operations.
    for (int t = 0; t < 25; t++) begin
      fill_random();
      run_op(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH - 1)),
             int'($urandom_range(3)), 1'($urandom));
    end
    // Maximum length, all-ones operands.
    for (int i = 0; i < DEPTH; i++) begin mem_ifm[i] = 8'hFF; mem_w[i] = 8'hFF; end
    run_op(17, DEPTH - 1, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
